// File: rtl/lcd_fmt_pkg.sv
// Shared character codes, FSM/mode encodings, text tables and glyph helpers
// for the LCD frame composer.
package lcd_fmt_pkg;

    localparam logic [7:0] CH_SPACE = 8'h20;
    localparam logic [7:0] CH_COLON = 8'h3A;
    localparam logic [7:0] CH_SLASH = 8'h2F;
    localparam logic [7:0] CH_DASH  = 8'h2D;
    localparam logic [7:0] CH_ZERO  = 8'h30;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RENDER = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        MODE_NORMAL    = 2'd0,
        MODE_SET_TIME  = 2'd1,
        MODE_SET_DATE  = 2'd2,
        MODE_SET_ALARM = 2'd3
    } mode_e;

    localparam logic [1:0] FIELD_NONE = 2'd3;

    // Weekday letter tables: byte w of WD_Cn is letter n of weekday w (0 = "EEE")
    localparam logic [63:0] WD_C0 = "SSFTWTME";
    localparam logic [63:0] WD_C1 = "uarheuoE";
    localparam logic [63:0] WD_C2 = "ntiudenE";

    // Byte 0 is the leftmost character
    localparam logic [71:0] STR_SET_TIME  = " EMIT TES";
    localparam logic [71:0] STR_SET_DATE  = " ETAD TES";
    localparam logic [71:0] STR_SET_ALARM = "MRALA TES";

    typedef struct packed {
        mode_e       mode;
        logic [1:0]  field;
        logic [23:0] tm;
        logic [23:0] dt;
        logic [2:0]  wd;
        logic [15:0] al;
        logic        al_on;
        logic        blink_on;
    } snap_t;

    function automatic logic [7:0] bcd_char(input logic [3:0] n);
        return (n > 4'd9) ? CH_DASH : CH_ZERO + {4'h0, n};
    endfunction

    // Column 0..7 of a "XX<sep>XX<sep>XX" group built from three BCD bytes
    function automatic logic [7:0] triple_char(input logic [23:0] v, input logic [7:0] sep,
                                               input logic [2:0] col);
        logic [7:0] b;
        logic [7:0] ch;
        case (col)
            3'd0, 3'd1: b = v[23:16];
            3'd3, 3'd4: b = v[15:8];
            default:    b = v[7:0];
        endcase
        case (col)
            3'd2, 3'd5:       ch = sep;
            3'd0, 3'd3, 3'd6: ch = bcd_char(b[7:4]);
            default:          ch = bcd_char(b[3:0]);
        endcase
        return ch;
    endfunction

    function automatic logic [7:0] str_char(input logic [71:0] s, input logic [3:0] col);
        logic [6:0] base;
        base = {col, 3'b000};
        return s[base +: 8];
    endfunction

endpackage

// File: rtl/lcd_tick_gen.sv
// Free-running divider: registered one-cycle tick every DIV clocks.
// Used for the frame refresh and, with LCD_BLINK_EN, the blink half-period.
module lcd_tick_gen #(
    parameter int unsigned DIV = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);
    localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q;
    logic          wrap_c;

    assign wrap_c = (cnt_q == CW'(DIV - 1));
    assign cnt_d  = wrap_c ? '0 : cnt_q + CW'(1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= wrap_c;
        end
    end

    assign tick_o = tick_q;

endmodule

// File: rtl/lcd_frame_composer.sv
// Renders both LCD text lines into shadow buffers one character per mclk and
// commits them atomically. Define LCD_BLINK_EN to blink the edited field.
module lcd_frame_composer
    import lcd_fmt_pkg::*;
#(
    parameter int unsigned M_FREQ     = 1,
    parameter int unsigned COLS       = 16,
    parameter int unsigned REFRESH_HZ = 10,
    parameter int unsigned BLINK_HZ   = 1
) (
    input  logic              mclk,
    input  logic              rst,
    input  logic [1:0]        clk_mode,
    input  logic [1:0]        edit_field,
    input  logic              force_refresh,
    input  logic [23:0]       time_bcd,
    input  logic [23:0]       date_bcd,
    input  logic [2:0]        weekday,
    input  logic [15:0]       alarm_bcd,
    input  logic              alarm_on,
    output logic [8*COLS-1:0] line_a,
    output logic [8*COLS-1:0] line_b,
    output logic              frame_stb,
    output logic              busy
);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned IW = CW + 1;
    localparam int unsigned BW = CW + 3;
    localparam int unsigned LW = 8 * COLS;
    localparam int unsigned REFRESH_DIV =
        (M_FREQ / REFRESH_HZ > 0) ? M_FREQ / REFRESH_HZ : 32'd1;

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          pending_q, pending_d;
    snap_t         snap_q, snap_in_c;
    logic [LW-1:0] shadow_a_q, shadow_b_q;
    logic [LW-1:0] line_a_q, line_b_q;
    logic          frame_stb_q, busy_q;

    logic          take_c, render_c, commit_c;
    logic          refresh_tick;
    logic          on_b_c, in_range_c, blank_c;
    logic [CW-1:0] col_c;
    logic [3:0]    c4_c;
    logic [7:0]    ch_a_c, ch_b_c;

    lcd_tick_gen #(.DIV(REFRESH_DIV)) u_refresh_tick (
        .clk_i  (mclk),
        .rst_i  (rst),
        .tick_o (refresh_tick)
    );

`ifdef LCD_BLINK_EN
    localparam int unsigned BLINK_DIV =
        (M_FREQ / (2 * BLINK_HZ) > 0) ? M_FREQ / (2 * BLINK_HZ) : 32'd1;

    logic       blink_tick;
    logic       blink_q;
    logic [3:0] fcol_c;

    lcd_tick_gen #(.DIV(BLINK_DIV)) u_blink_tick (
        .clk_i  (mclk),
        .rst_i  (rst),
        .tick_o (blink_tick)
    );

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            blink_q <= 1'b1;
        end else if (blink_tick) begin
            blink_q <= ~blink_q;
        end
    end

    // Field 2 in alarm mode maps to cols 6-7, which are blank there anyway
    always_comb begin
        fcol_c  = {2'b00, snap_q.field} + {1'b0, snap_q.field, 1'b0};
        blank_c = (snap_q.mode != MODE_NORMAL) && !snap_q.blink_on &&
                  (snap_q.field != FIELD_NONE) &&
                  ((c4_c == fcol_c) || (c4_c == fcol_c + 4'd1));
    end
`else
    logic unused_blink_c;
    assign unused_blink_c = ^{snap_q.field, snap_q.blink_on};
    assign blank_c        = 1'b0;
`endif

    // Data snapshot taken when a frame starts
    always_comb begin
        snap_in_c       = '0;
        snap_in_c.mode  = mode_e'(clk_mode);
        snap_in_c.field = edit_field;
        snap_in_c.tm    = time_bcd;
        snap_in_c.dt    = date_bcd;
        snap_in_c.wd    = weekday;
        snap_in_c.al    = alarm_bcd;
        snap_in_c.al_on = alarm_on;
`ifdef LCD_BLINK_EN
        snap_in_c.blink_on = blink_q;
`else
        snap_in_c.blink_on = 1'b1;
`endif
    end

    // Next-state logic
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        take_c   = 1'b0;
        render_c = 1'b0;
        commit_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pending_q) begin
                    take_c  = 1'b1;
                    idx_d   = '0;
                    state_d = ST_RENDER;
                end
            end
            ST_RENDER: begin
                render_c = 1'b1;
                if (idx_q == IW'(2 * COLS - 1)) begin
                    state_d = ST_COMMIT;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            ST_COMMIT: begin
                commit_c = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        pending_d = (pending_q & ~take_c) | refresh_tick | force_refresh;
    end

    // Character generator for the current render column
    always_comb begin
        on_b_c     = (idx_q >= IW'(COLS));
        col_c      = on_b_c ? CW'(idx_q - IW'(COLS)) : CW'(idx_q);
        in_range_c = ((col_c >> 4) == '0);
        c4_c       = col_c[3:0];
        ch_a_c     = CH_SPACE;
        ch_b_c     = CH_SPACE;
        if (in_range_c) begin
            case (snap_q.mode)
                MODE_NORMAL: begin
                    if (c4_c < 4'd8)       ch_a_c = triple_char(snap_q.tm, CH_COLON, c4_c[2:0]);
                    else if (c4_c == 4'd9)  ch_a_c = WD_C0[{snap_q.wd, 3'b000} +: 8];
                    else if (c4_c == 4'd10) ch_a_c = WD_C1[{snap_q.wd, 3'b000} +: 8];
                    else if (c4_c == 4'd11) ch_a_c = WD_C2[{snap_q.wd, 3'b000} +: 8];
                    if (c4_c < 4'd8) begin
                        ch_b_c = triple_char(snap_q.dt, CH_SLASH, c4_c[2:0]);
                    end else if (snap_q.al_on && (c4_c >= 4'd11)) begin
                        ch_b_c = triple_char({snap_q.al, 8'h00}, CH_COLON, 3'(c4_c - 4'd11));
                    end
                end
                MODE_SET_TIME: begin
                    if (c4_c < 4'd8) ch_a_c = triple_char(snap_q.tm, CH_COLON, c4_c[2:0]);
                    if (c4_c < 4'd9) ch_b_c = str_char(STR_SET_TIME, c4_c);
                end
                MODE_SET_DATE: begin
                    if (c4_c < 4'd8) ch_a_c = triple_char(snap_q.dt, CH_SLASH, c4_c[2:0]);
                    if (c4_c < 4'd9) ch_b_c = str_char(STR_SET_DATE, c4_c);
                end
                MODE_SET_ALARM: begin
                    if (c4_c < 4'd5) ch_a_c = triple_char({snap_q.al, 8'h00}, CH_COLON, c4_c[2:0]);
                    if (c4_c < 4'd9) ch_b_c = str_char(STR_SET_ALARM, c4_c);
                end
                default: ;
            endcase
            if (blank_c) ch_a_c = CH_SPACE;
        end
    end

    always_ff @(posedge mclk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            pending_q   <= 1'b0;
            snap_q      <= '0;
            shadow_a_q  <= {COLS{CH_SPACE}};
            shadow_b_q  <= {COLS{CH_SPACE}};
            line_a_q    <= {COLS{CH_SPACE}};
            line_b_q    <= {COLS{CH_SPACE}};
            frame_stb_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            if (take_c) snap_q <= snap_in_c;
            if (render_c) begin
                if (on_b_c) shadow_b_q[{col_c, 3'b000} +: 8] <= ch_b_c;
                else        shadow_a_q[{col_c, 3'b000} +: 8] <= ch_a_c;
            end
            if (commit_c) begin
                line_a_q <= shadow_a_q;
                line_b_q <= shadow_b_q;
            end
            frame_stb_q <= commit_c;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign line_a    = line_a_q;
    assign line_b    = line_b_q;
    assign frame_stb = frame_stb_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_lcd_frame_composer.sv
// Directed self-checking bench for lcd_frame_composer (M_FREQ=100, COLS=16).
module tb_lcd_frame_composer;

    localparam int unsigned COLS = 16;
    localparam int unsigned W    = 8 * COLS;

    logic         mclk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   clk_mode = 2'd0;
    logic [1:0]   edit_field = 2'd3;
    logic         force_refresh = 1'b0;
    logic [23:0]  time_bcd = 24'h123456;
    logic [23:0]  date_bcd = 24'h051124;
    logic [2:0]   weekday = 3'd1;
    logic [15:0]  alarm_bcd = 16'h0730;
    logic         alarm_on = 1'b0;
    logic [W-1:0] line_a, line_b;
    logic         frame_stb, busy;

    int errors = 0;
    int checks = 0;

    lcd_frame_composer #(
        .M_FREQ(100), .COLS(COLS), .REFRESH_HZ(10), .BLINK_HZ(1)
    ) dut (
        .mclk(mclk), .rst(rst), .clk_mode(clk_mode), .edit_field(edit_field),
        .force_refresh(force_refresh), .time_bcd(time_bcd), .date_bcd(date_bcd),
        .weekday(weekday), .alarm_bcd(alarm_bcd), .alarm_on(alarm_on),
        .line_a(line_a), .line_b(line_b), .frame_stb(frame_stb), .busy(busy)
    );

    always #5 mclk = ~mclk;

    task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Text to line image, byte 0 leftmost, padded with spaces
    function automatic logic [W-1:0] txt(input string s);
        logic [W-1:0] v;
        v = {COLS{8'h20}};
        for (int i = 0; i < s.len() && i < int'(COLS); i++) v[8*i +: 8] = s[i];
        return v;
    endfunction

    task automatic do_reset();
        @(negedge mclk);
        rst = 1'b1;
        repeat (3) @(negedge mclk);
        rst = 1'b0;
    endtask

    // Pulse force_refresh; n = edges after the sampling edge until frame_stb (-1 on timeout)
    task automatic frame_wait(output int n, output logic busy1);
        n = -1;
        busy1 = 1'b0;
        force_refresh = 1'b1;
        @(posedge mclk); #1;
        force_refresh = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge mclk); #1;
            if (k == 1) busy1 = busy;
            if (frame_stb) begin
                n = k;
                break;
            end
        end
    endtask

    string exp_a [3];
    string exp_b [3];

    initial begin
        int   n;
        logic b1;
        int   cnt, k1, k2, saw_on, saw_off;
        logic [W-1:0] la1, la2, mask, ref_a;

        exp_a = '{"12:34:56", "05/11/24", "07:30"};
        exp_b = '{"SET TIME", "SET DATE", "SET ALARM"};

        // Asynchronous reset before any clock edge
        #1 rst = 1'b1;
        #1;
        check("rst_line_a", line_a, txt(""));
        check("rst_line_b", line_b, txt(""));
        check("rst_stb", W'(frame_stb), W'(1'b0));
        check("rst_busy", W'(busy), W'(1'b0));

        // Mode 0 frame, no alarm
        do_reset();
        frame_wait(n, b1);
        check("m0_latency", W'(n), W'(34));
        check("m0_busy_start", W'(b1), W'(1'b1));
        check("m0_busy_commit", W'(busy), W'(1'b0));
        check("m0_line_a", line_a, txt("12:34:56 Mon"));
        check("m0_line_b", line_b, txt("05/11/24"));
        @(posedge mclk); #1;
        check("m0_stb_one_cycle", W'(frame_stb), W'(1'b0));

        // Mode 0 with alarm armed
        alarm_on = 1'b1;
        do_reset();
        frame_wait(n, b1);
        check("alarm_latency", W'(n), W'(34));
        check("alarm_line_b", line_b, txt("05/11/24   07:30"));

        // Set modes 1..3
        for (int m = 1; m <= 3; m++) begin
            clk_mode = 2'(m);
            do_reset();
            frame_wait(n, b1);
            check($sformatf("mode%0d_latency", m), W'(n), W'(34));
            check($sformatf("mode%0d_line_a", m), line_a, txt(exp_a[m-1]));
            check($sformatf("mode%0d_line_b", m), line_b, txt(exp_b[m-1]));
        end

        // Edited field in set-time mode; cols 3-4 blink only with LCD_BLINK_EN
        clk_mode = 2'd1;
        edit_field = 2'd1;
        alarm_on = 1'b0;
        do_reset();
        frame_wait(n, b1);
        check("blink_first_on", line_a, txt("12:34:56"));
        ref_a = txt("12:34:56");
        mask = ~(W'(32'hFFFF) << 24);
        saw_on = 0;
        saw_off = 0;
        for (int k = 0; k < 320; k++) begin
            @(posedge mclk); #1;
            if (frame_stb) begin
                check("blink_steady_cols", line_a & mask, ref_a & mask);
                if (line_a[39:24] == ref_a[39:24]) saw_on++;
                else if (line_a[39:24] == 16'h2020) saw_off++;
                else check("blink_mid_legal", W'(line_a[39:24]), W'(ref_a[39:24]));
            end
        end
        check("blink_saw_on", W'(saw_on > 0), W'(1'b1));
`ifdef LCD_BLINK_EN
        check("blink_saw_off", W'(saw_off > 0), W'(1'b1));
`else
        check("steady_no_blank", W'(saw_off), W'(0));
`endif

        // Requests while busy collapse; input change mid-render lands in the next frame
        clk_mode = 2'd0;
        edit_field = 2'd3;
        time_bcd = 24'h123456;
        do_reset();
        force_refresh = 1'b1;
        @(posedge mclk); #1;
        force_refresh = 1'b0;
        cnt = 0; k1 = 0; k2 = 0; la1 = '0; la2 = '0;
        for (int k = 1; k <= 68; k++) begin
            @(posedge mclk); #1;
            force_refresh = (k == 3) || (k == 6);
            if (k == 5) time_bcd = 24'h123457;
            if (frame_stb) begin
                cnt++;
                if (cnt == 1) begin k1 = k; la1 = line_a; end
                if (cnt == 2) begin k2 = k; la2 = line_a; end
            end
        end
        force_refresh = 1'b0;
        check("collapse_count", W'(cnt), W'(2));
        check("collapse_first_at", W'(k1), W'(34));
        check("collapse_second_at", W'(k2), W'(68));
        check("collapse_frame1", la1, txt("12:34:56 Mon"));
        check("collapse_frame2", la2, txt("12:34:57 Mon"));

        // Non-BCD nibble renders a dash; then reset in the middle of a render
        time_bcd = 24'h1A0000;
        do_reset();
        frame_wait(n, b1);
        check("dash_latency", W'(n), W'(34));
        check("dash_line_a", line_a, txt("1-:00:00 Mon"));
        repeat (11) @(posedge mclk);
        #1;
        check("midrender_busy", W'(busy), W'(1'b1));
        rst = 1'b1;
        #1;
        check("midrst_line_a", line_a, txt(""));
        check("midrst_line_b", line_b, txt(""));
        check("midrst_stb", W'(frame_stb), W'(1'b0));
        check("midrst_busy", W'(busy), W'(1'b0));
        @(negedge mclk);
        @(negedge mclk);
        rst = 1'b0;
        cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge mclk); #1;
            if (frame_stb) cnt++;
        end
        check("midrst_no_stb", W'(cnt), W'(0));
        check("midrst_lines_stay", line_a, txt(""));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lcd_frame_composer.md
Name: lcd_frame_composer

Overview:
- Parametrised successor to the single-field weekday display logic.
- Builds both LCD text lines from clock-core state: time, date, weekday and alarm, in BCD.
- Selects the screen layout from clk_mode and can blink the field being edited.
- Renders one character per mclk into shadow buffers, then commits both lines atomically, so the downstream lcd_controller never sees a torn frame.

Parameters:
M_FREQ, 1, mclk frequency in Hz (20_000_000 on board; 100 in benches)
COLS, 16, characters per line (>=16); columns 16..COLS-1 always render space
REFRESH_HZ, 10, frame render rate; divider = max(1, M_FREQ/REFRESH_HZ)
BLINK_HZ, 1, blink rate of the edited field; half-period = max(1, M_FREQ/(2*BLINK_HZ))

Ports:
mclk  in  1  main clock, the single clock
rst  in  1  asynchronous, active-high reset
clk_mode  in  2  0 normal, 1 set time, 2 set date, 3 set alarm
edit_field  in  2  field being edited: 0 first (HH/DD), 1 second (MM), 2 third (SS/YY), 3 none
force_refresh  in  1  one-cycle pulse requesting an immediate render
time_bcd  in  24  {HH,MM,SS}, one BCD byte each
date_bcd  in  24  {DD,MM,YY}
weekday  in  3  0 renders "EEE", 1..7 render Mon..Sun
alarm_bcd  in  16  {HH,MM}
alarm_on  in  1  alarm armed
line_a  out  8*COLS  line 1; byte [7:0] is the leftmost column
line_b  out  8*COLS  line 2
frame_stb  out  1  one-cycle pulse when line_a/line_b update
busy  out  1  high while the FSM is not IDLE

Behaviour:
- Reset (async): line_a = line_b = all 0x20; frame_stb = 0; busy = 0; FSM IDLE; pending flag clear; dividers cleared; blink phase = on.
- Character set: digit = 0x30 + nibble; nibble > 9 renders '-' (0x2D); ':' 0x3A; '/' 0x2F; space 0x20.
- Layouts (columns from 0):
  - Mode 0: A = "HH:MM:SS Www"; B = "DD/MM/YY" at cols 0-7, plus "HH:MM" of the alarm at cols 11-15 when alarm_on, otherwise spaces there.
  - Mode 1: A = time; B = "SET TIME".
  - Mode 2: A = "DD/MM/YY"; B = "SET DATE".
  - Mode 3: A = alarm "HH:MM"; B = "SET ALARM".
  - All unlisted columns are spaces.
- Edit field columns on line A: field 0 = cols 0-1, field 1 = cols 3-4, field 2 = cols 6-7. Field 2 in mode 3 does not exist, so nothing blinks.
- Refresh tick: a free-running divider pulses once per refresh period. A tick or force_refresh sets pending.
- FSM:
  - IDLE: if pending, snapshot all data inputs and the blink phase, clear pending, go to RENDER.
  - RENDER: idx counts 0..2*COLS-1, one character per cycle. idx < COLS writes shadow A, otherwise shadow B.
  - COMMIT: copy both shadows to line_a/line_b, assert frame_stb for that one cycle, go to IDLE.
- Latency: with pending set while IDLE at edge e, the outputs change and frame_stb goes high at edge e + 2*COLS + 1.
- Requests arriving while busy collapse into a single pending frame. That frame starts on the cycle after COMMIT (IDLE with pending lasts one cycle).
- A tick and force_refresh in the same cycle set pending once.
- Input changes after the snapshot do not affect the frame in progress.
- Reset mid-render: outputs return to spaces immediately; no frame_stb is issued.

Optional Feature:
- LCD_BLINK_EN defined:
  - The blink divider toggles the phase every half-period.
  - When clk_mode != 0 and the snapshotted phase is off, the columns of the edited field render 0x20.
- LCD_BLINK_EN undefined:
  - No blink divider is built.
  - Edited fields render steadily; edit_field is ignored.

Decomposition:
- Package lcd_fmt_pkg holds:
  - character constants (CH_SPACE, CH_COLON, CH_SLASH, CH_DASH, CH_ZERO);
  - the FSM state encoding (IDLE, RENDER, COMMIT);
  - 3x8-byte weekday name tables;
  - "SET TIME"/"SET DATE"/"SET ALARM" strings;
  - mode codes.
- Sub-module lcd_tick_gen: parametrised divider producing the refresh tick and, under LCD_BLINK_EN, the blink phase. Instantiated twice, or once with two outputs.

Test Plan:
- Bench settings: M_FREQ=100, REFRESH_HZ=10, BLINK_HZ=1, COLS=16.
- Assert rst -> line_a, line_b all 0x20; frame_stb=0; busy=0, checked asynchronously before any edge.
- Mode 0, time 12:34:56, weekday 1, date 05/11/24, alarm_on 0, one force_refresh -> 34 edges later line_a = "12:34:56 Mon" + 4 spaces and line_b = "05/11/24" + 8 spaces; frame_stb high exactly 1 cycle.
- Same inputs plus alarm_on=1, alarm 07:30 -> line_b cols 11-15 = "07:30".
- LCD_BLINK_EN, mode 1, edit_field 1 -> line_a cols 3-4 alternate "34" and two 0x20 every 50 mclk; cols 0-1 and 6-7 stay steady.
- Two force_refresh pulses while busy -> exactly two frame_stb in total, the second 34 cycles after the first commit; a change in time_bcd mid-render is absent from the first frame and present in the second.
- time_bcd = 0x1A_00_00 -> line_a col 1 = 0x2D; assert rst at idx 10 -> outputs all spaces and no frame_stb until the next request.
